// File: rtl/road_pkg.sv
// Shared types and widths for the road-marking scroll controller.
`default_nettype none

package road_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_ACCEL   = 2'd1,
    ST_CRUISE  = 2'd2,
    ST_BRAKE   = 2'd3
  } road_state_e;

  localparam int POS_W  = 11;
  localparam int FRAC_W = 2;
  localparam int SPD_W  = 4;
  localparam int Y_W    = 9;

endpackage

`default_nettype wire

// File: rtl/road_tick_div.sv
// Modulo-N counter with enable and clear; wrap_o is a strobe for the enabled cycle at N-1.
`default_nettype none

module road_tick_div #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  // Clear wins over enable so a state change always restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/road_scroll_ctrl.sv
// Per-frame road scroll controller: sub-pixel position, speed ramp FSM and sprite animation index.
`default_nettype none

module road_scroll_ctrl
  import road_pkg::*;
#(
  parameter int SPR_COUNT = 4,
  parameter int RAMP_DIV  = 4,
  parameter int ANIM_DIV  = 8,
  parameter int MAX_SPEED = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             run,
  input  logic [SPD_W-1:0] target_speed,
  output logic [Y_W-1:0]   Y,
  output logic [8:0]       sprite_number,
  output logic [SPD_W-1:0] speed,
  output logic             moving
);

  localparam logic [SPD_W-1:0] MAX_SPD  = SPD_W'(MAX_SPEED);
  localparam logic [8:0]       SPR_LAST = 9'(SPR_COUNT - 1);

  road_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q;
  logic [SPD_W-1:0] speed_q, speed_next, tgt;
  logic [8:0]       sprite_q;
  logic             moving_q;
  logic             ramp_active, ramp_en, ramp_clr, ramp_wrap;
  logic             anim_en, anim_wrap;

  assign tgt         = (target_speed > MAX_SPD) ? MAX_SPD : target_speed;
  assign ramp_active = (state_q == ST_ACCEL) || (state_q == ST_BRAKE);
  assign ramp_en     = frame_tick && ramp_active;
  assign ramp_clr    = frame_tick && (!ramp_active || (state_d != state_q));
  assign anim_en     = frame_tick && (speed_q != '0);

  road_tick_div #(.N(RAMP_DIV)) u_ramp_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ramp_en),
    .clr_i  (ramp_clr),
    .wrap_o (ramp_wrap)
  );

  road_tick_div #(.N(ANIM_DIV)) u_anim_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (anim_en),
    .clr_i  (1'b0),
    .wrap_o (anim_wrap)
  );

  always_comb begin
    speed_next = speed_q;
    if (ramp_wrap) begin
      if (state_q == ST_ACCEL && speed_q < tgt) begin
        speed_next = speed_q + 1'b1;
      end else if (state_q == ST_BRAKE && speed_q != '0) begin
        speed_next = speed_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOPPED: begin
        if (run && tgt != '0) state_d = ST_ACCEL;
      end
      ST_ACCEL: begin
        if (!run || tgt < speed_next)  state_d = ST_BRAKE;
        else if (tgt == speed_next)    state_d = ST_CRUISE;
      end
      ST_CRUISE: begin
        if (!run || tgt < speed_next)  state_d = ST_BRAKE;
        else if (tgt > speed_next)     state_d = ST_ACCEL;
      end
      ST_BRAKE: begin
        if (speed_next == '0 && (!run || tgt == '0))           state_d = ST_STOPPED;
        else if (run && tgt > speed_next)                        state_d = ST_ACCEL;
        else if (run && tgt == speed_next && speed_next != '0)   state_d = ST_CRUISE;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Everything advances only on a frame tick so a frame never sees mixed offsets.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_STOPPED;
      pos_q    <= '0;
      speed_q  <= '0;
      sprite_q <= '0;
      moving_q <= 1'b0;
    end else if (frame_tick) begin
      state_q  <= state_d;
      pos_q    <= pos_q + {{(POS_W-SPD_W){1'b0}}, speed_q};
      speed_q  <= speed_next;
      moving_q <= (speed_next != '0);
      if (anim_wrap) begin
        sprite_q <= (sprite_q == SPR_LAST) ? '0 : sprite_q + 9'd1;
      end
    end
  end

  assign Y             = pos_q[POS_W-1:FRAC_W];
  assign sprite_number = sprite_q;
  assign speed         = speed_q;
  assign moving        = moving_q;

endmodule

`default_nettype wire

// File: tb/tb_road_scroll_ctrl.sv
// Scoreboard bench for road_scroll_ctrl against a frame-level behavioural model.
`default_nettype none

module tb_road_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic [3:0] target_speed = 4'd0;
  logic [8:0] Y;
  logic [8:0] sprite_number;
  logic [3:0] speed;
  logic       moving;

  road_scroll_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .run           (run),
    .target_speed  (target_speed),
    .Y             (Y),
    .sprite_number (sprite_number),
    .speed         (speed),
    .moving        (moving)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] y;
    logic [8:0] spr;
    logic [3:0] spd;
    logic       mv;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   seen_wrap = 1'b0;
  bit   done = 1'b0;

  // Model state: position in quarter pixels, speed, counters and a mode name.
  localparam int M_STOP = 0, M_ACC = 1, M_CRU = 2, M_BRK = 3;
  int m_pos = 0, m_spd = 0, m_spr = 0, m_ac = 0, m_rc = 0, m_mode = M_STOP;

  task automatic model_step(input bit tk, input bit rn, input int ts, input bit rs);
    int t, ns, nm;
    bit step;
    if (rs) begin
      m_pos = 0; m_spd = 0; m_spr = 0; m_ac = 0; m_rc = 0; m_mode = M_STOP;
    end else if (tk) begin
      t = (ts > 12) ? 12 : ts;
      ns = m_spd;
      step = 1'b0;
      if (m_mode == M_ACC || m_mode == M_BRK) begin
        if (m_rc == 3) begin m_rc = 0; step = 1'b1; end
        else m_rc++;
      end else m_rc = 0;
      if (step && m_mode == M_ACC && ns < t) ns++;
      if (step && m_mode == M_BRK && ns > 0) ns--;
      nm = m_mode;
      case (m_mode)
        M_STOP: if (rn && t > 0) nm = M_ACC;
        M_ACC:  if (!rn || t < ns) nm = M_BRK; else if (t == ns) nm = M_CRU;
        M_CRU:  if (!rn || t < ns) nm = M_BRK; else if (t > ns) nm = M_ACC;
        default: begin
          if (ns == 0 && (!rn || t == 0)) nm = M_STOP;
          else if (rn && t > ns) nm = M_ACC;
          else if (rn && t == ns && ns != 0) nm = M_CRU;
        end
      endcase
      if (nm != m_mode) m_rc = 0;
      if (m_spd != 0) begin
        m_ac = (m_ac + 1) % 8;
        if (m_ac == 0) m_spr = (m_spr + 1) % 4;
      end
      m_pos = (m_pos + m_spd) % 2048;
      m_spd = ns;
      m_mode = nm;
    end
  endtask

  task automatic cyc(input bit tk, input bit rn, input logic [3:0] ts, input bit rs);
    exp_t e;
    @(negedge clk);
    frame_tick = tk; run = rn; target_speed = ts; rst = rs;
    model_step(tk, rn, int'(ts), rs);
    e.y = 9'(m_pos / 4); e.spr = 9'(m_spr); e.spd = 4'(m_spd); e.mv = (m_spd != 0);
    exp_q.push_back(e);
  endtask

  task automatic ticks(input int n, input int gap, input bit rn, input logic [3:0] ts);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, rn, ts, 1'b0);
      for (int j = 0; j < gap; j++) cyc(1'b0, rn, ts, 1'b0);
    end
  endtask

  // Monitor: one expected entry per driven cycle, compared one cycle later.
  initial begin
    exp_t e;
    logic [8:0] prev_y = 9'd0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nvec++;
        if (prev_y >= 9'd500 && Y <= 9'd20) seen_wrap = 1'b1;
        prev_y = Y;
        if (Y !== e.y) begin
          nerr++; $display("FAIL Y t=%0t got %0d want %0d", $time, Y, e.y);
        end
        if (sprite_number !== e.spr) begin
          nerr++; $display("FAIL sprite_number t=%0t got %0d want %0d", $time, sprite_number, e.spr);
        end
        if (speed !== e.spd) begin
          nerr++; $display("FAIL speed t=%0t got %0d want %0d", $time, speed, e.spd);
        end
        if (moving !== e.mv) begin
          nerr++; $display("FAIL moving t=%0t got %0b want %0b", $time, moving, e.mv);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset coinciding with a frame tick.
    cyc(1'b1, 1'b1, 4'd4, 1'b1);
    cyc(1'b0, 1'b1, 4'd4, 1'b0);
    // Slow ramp to 4, then cruise.
    ticks(25, 99, 1'b1, 4'd4);
    // Clamp at 12 and wrap Y, back-to-back ticks.
    ticks(250, 0, 1'b1, 4'd15);
    // Brake mid-ramp from a fresh start.
    cyc(1'b0, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 40 && m_spd != 2; k++) ticks(1, 1, 1'b1, 4'd4);
    ticks(20, 2, 1'b0, 4'd4);
    // Constant speed 4 for animation, then long idle hold.
    ticks(60, 1, 1'b1, 4'd4);
    for (int k = 0; k < 10000; k++) cyc(1'b0, 1'b0, 4'd9, 1'b0);
    // Reset during cruise, then a stopped tick.
    cyc(1'b0, 1'b1, 4'd4, 1'b1);
    ticks(2, 3, 1'b0, 4'd4);
    // Randomised traffic, including mid-ramp target changes and occasional reset.
    for (int k = 0; k < 4000; k++) begin
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) != 0),
          4'($urandom_range(0, 15)), ($urandom_range(0, 699) == 0));
    end
    cyc(1'b0, 1'b0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    nvec++;
    if (!seen_wrap) begin
      nerr++; $display("FAIL y_wrap observed %0b want 1", seen_wrap);
    end
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++; $display("FAIL queue_drain left %0d want 0", exp_q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
